// File: rtl/controller_unit_pkg.sv
// Shared widths, instruction/address payloads, FSM state encoding and strobe decode
// for the upsampler sequencer.
package controller_unit_pkg;

   localparam int unsigned PS_ADDR_W   = 4;
   localparam int unsigned DRAM_ADDR_W = 8;
   localparam int unsigned CRAM_ADDR_W = 8;
   localparam int unsigned LEN_W       = 8;
   localparam int unsigned N_STROBES   = 12;

   // Allocation instruction as stored in the program store (26 bits, dptr in MSBs)
   typedef struct packed {
      logic [DRAM_ADDR_W-1:0] dptr;
      logic [CRAM_ADDR_W-1:0] cptr;
      logic [LEN_W-1:0]       len;
      logic                   sat_en;
      logic                   new_smp;
   } alloc_instr_t;

   // Address bus driven to one RAM port pair
   typedef struct packed {
      logic [DRAM_ADDR_W-1:0] dram_addr;
      logic [CRAM_ADDR_W-1:0] cram_addr;
   } addr_bus_t;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_FETCH = 4'd1,
      ST_LOAD  = 4'd2,
      ST_CALC  = 4'd3,
      ST_RES   = 4'd4,
      ST_ERR   = 4'd5,
      ST_OUT   = 4'd6,
      ST_NEW   = 4'd7,
      ST_INCR  = 4'd8
   } state_t;

   // Active-low strobe vector, MSB first: en_ram_pa, en_ram_pb, en_mac, rw_regf,
   // rw_ramp1, rw_ramp2, r_alocinstr, mac_init, load, res_err, new_in, new_out
   function automatic logic [N_STROBES-1:0] strobe_decode(input state_t s);
      case (s)
         ST_FETCH: strobe_decode = 12'b1111_1101_1111;
         ST_LOAD:  strobe_decode = 12'b0100_1110_1111;
         ST_CALC:  strobe_decode = 12'b0001_1111_1111;
         ST_RES:   strobe_decode = 12'b1101_1111_0011;
         ST_ERR:   strobe_decode = 12'b1101_1111_0111;
         ST_OUT:   strobe_decode = 12'b1110_1111_1110;
         ST_NEW:   strobe_decode = 12'b1111_1111_1101;
         default:  strobe_decode = 12'b1111_1111_1111;
      endcase
   endfunction

endpackage

// File: rtl/controller_unit.sv
// Moore sequencer: fetches allocation instructions, walks data/coef pointers through
// the MAC loop and steps the result/output/new-sample strobes.
import controller_unit_pkg::*;

module controller_unit (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  alloc_instr_t allocs_word,
   output logic         en_ram_pa,
   output logic         en_ram_pb,
   output logic         en_mac,
   output logic         rw_regf,
   output logic         rw_ramp1,
   output logic         rw_ramp2,
   output logic         r_alocinstr,
   output logic         mac_init,
   output logic         load,
   output logic         res_err,
   output logic         new_in,
   output logic         new_out,
   output addr_bus_t    addr_bus_1,
   output addr_bus_t    addr_bus_2,
   output state_t       ostate
);

   state_t                 state;
   logic [PS_ADDR_W-1:0]   pc;
   alloc_instr_t           instr;
   logic [DRAM_ADDR_W-1:0] dptr;
   logic [CRAM_ADDR_W-1:0] cptr;
   logic [LEN_W-1:0]       cnt;
   addr_bus_t              hold_1;
   addr_bus_t              hold_2;

   // State, program counter, instruction and pointer/count registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         pc     <= '0;
         instr  <= '0;
         dptr   <= '0;
         cptr   <= '0;
         cnt    <= '0;
         hold_1 <= '0;
         hold_2 <= '0;
      end else begin
         hold_1 <= addr_bus_1;
         hold_2 <= addr_bus_2;
         case (state)
            ST_IDLE: begin
               if (en) state <= ST_FETCH;
            end
            ST_FETCH: begin
               instr <= allocs_word;
               state <= ST_LOAD;
            end
            ST_LOAD: begin
               dptr  <= instr.dptr;
               cptr  <= instr.cptr;
               // a zero-length loop still runs one MAC cycle
               cnt   <= (instr.len == '0) ? LEN_W'(1) : instr.len;
               state <= ST_CALC;
            end
            ST_CALC: begin
               dptr <= dptr + DRAM_ADDR_W'(1);
               cptr <= cptr + CRAM_ADDR_W'(1);
               cnt  <= cnt - LEN_W'(1);
               if (cnt == LEN_W'(1)) state <= instr.sat_en ? ST_ERR : ST_RES;
            end
            ST_RES, ST_ERR: state <= ST_OUT;
            ST_OUT:  state <= instr.new_smp ? ST_NEW : ST_INCR;
            ST_NEW:  state <= ST_INCR;
            ST_INCR: begin
               pc    <= pc + PS_ADDR_W'(1);
               state <= en ? ST_FETCH : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Address buses: program address in fetch, pointers in calc, otherwise hold
   always_comb begin
      addr_bus_1 = hold_1;
      addr_bus_2 = hold_2;
      case (state)
         ST_FETCH: begin
            addr_bus_1.dram_addr = DRAM_ADDR_W'(pc);
            addr_bus_1.cram_addr = '0;
            addr_bus_2           = '0;
         end
         ST_CALC: begin
            addr_bus_1.dram_addr = dptr;
            addr_bus_1.cram_addr = '0;
            addr_bus_2.dram_addr = '0;
            addr_bus_2.cram_addr = cptr;
         end
         default: ;
      endcase
   end

   // Strobes are a pure decode of the current state
   assign {en_ram_pa, en_ram_pb, en_mac, rw_regf, rw_ramp1, rw_ramp2,
           r_alocinstr, mac_init, load, res_err, new_in, new_out} = strobe_decode(state);

   assign ostate = state;

endmodule

// File: tb/tb_controller_unit.sv
// Directed self-checking bench for controller_unit.
import controller_unit_pkg::*;

module tb_controller_unit;

   localparam logic [11:0] STB_S1   = 12'b111111011111;
   localparam logic [11:0] STB_S2   = 12'b010011101111;
   localparam logic [11:0] STB_S3   = 12'b000111111111;
   localparam logic [11:0] STB_S4   = 12'b110111110011;
   localparam logic [11:0] STB_S5   = 12'b110111110111;
   localparam logic [11:0] STB_S6   = 12'b111011111110;
   localparam logic [11:0] STB_S7   = 12'b111111111101;
   localparam logic [11:0] STB_IDLE = 12'b111111111111;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   alloc_instr_t allocs_word;
   logic en_ram_pa, en_ram_pb, en_mac, rw_regf, rw_ramp1, rw_ramp2;
   logic r_alocinstr, mac_init, load, res_err, new_in, new_out;
   addr_bus_t    addr_bus_1, addr_bus_2;
   state_t       ostate;

   alloc_instr_t prog [16];
   int n_checks = 0;
   int n_errors = 0;

   controller_unit dut (
      .clk(clk), .rst(rst), .en(en), .allocs_word(allocs_word),
      .en_ram_pa(en_ram_pa), .en_ram_pb(en_ram_pb), .en_mac(en_mac),
      .rw_regf(rw_regf), .rw_ramp1(rw_ramp1), .rw_ramp2(rw_ramp2),
      .r_alocinstr(r_alocinstr), .mac_init(mac_init), .load(load),
      .res_err(res_err), .new_in(new_in), .new_out(new_out),
      .addr_bus_1(addr_bus_1), .addr_bus_2(addr_bus_2), .ostate(ostate)
   );

   always #5 clk = ~clk;

   // Program store answers the address presented on port 1
   always_comb allocs_word = prog[addr_bus_1.dram_addr[3:0]];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_st(input string tag, input logic [3:0] exp_st, input logic [11:0] exp_stb);
      logic [11:0] stb;
      stb = {en_ram_pa, en_ram_pb, en_mac, rw_regf, rw_ramp1, rw_ramp2,
             r_alocinstr, mac_init, load, res_err, new_in, new_out};
      check({tag, "_state"}, 32'(ostate), 32'(exp_st));
      check({tag, "_strobes"}, 32'(stb), 32'(exp_stb));
   endtask

   task automatic check_addr(input string tag, input logic [15:0] exp1, input logic [15:0] exp2);
      check({tag, "_addr1"}, 32'(addr_bus_1), 32'(exp1));
      check({tag, "_addr2"}, 32'(addr_bus_2), 32'(exp2));
   endtask

   task automatic wait_state(input string tag, input logic [3:0] target, input int budget);
      int n;
      n = 0;
      while (ostate != state_t'(target) && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_reach"}, 32'(ostate), 32'(target));
   endtask

   initial begin
      prog[0] = '{dptr: 8'h10, cptr: 8'h20, len: 8'd3, sat_en: 1'b0, new_smp: 1'b1};
      prog[1] = '{dptr: 8'h30, cptr: 8'h40, len: 8'd0, sat_en: 1'b1, new_smp: 1'b0};
      for (int i = 2; i < 16; i++)
         prog[i] = '{dptr: 8'(i), cptr: 8'(8'h80 + i), len: 8'd1, sat_en: 1'b0, new_smp: 1'b0};

      // reset and idle hold
      rst = 1'b1; en = 1'b0;
      tick(); tick();
      check_st("reset", 4'd0, STB_IDLE);
      check_addr("reset", 16'h0000, 16'h0000);
      rst = 1'b0;
      tick(); tick();
      check_st("idle_hold", 4'd0, STB_IDLE);

      // instruction 0: len 3, no saturation, new sample
      en = 1'b1;
      tick(); check_st("i0_s1", 4'd1, STB_S1); check_addr("i0_s1", 16'h0000, 16'h0000);
      tick(); check_st("i0_s2", 4'd2, STB_S2);
      tick(); check_st("i0_s3a", 4'd3, STB_S3); check_addr("i0_s3a", 16'h1000, 16'h0020);
      tick(); check_st("i0_s3b", 4'd3, STB_S3); check_addr("i0_s3b", 16'h1100, 16'h0021);
      tick(); check_st("i0_s3c", 4'd3, STB_S3); check_addr("i0_s3c", 16'h1200, 16'h0022);
      tick(); check_st("i0_s4", 4'd4, STB_S4); check_addr("i0_hold", 16'h1200, 16'h0022);
      tick(); check_st("i0_s6", 4'd6, STB_S6);
      tick(); check_st("i0_s7", 4'd7, STB_S7);
      tick(); check_st("i0_s8", 4'd8, STB_IDLE);
      tick(); check_st("i1_s1", 4'd1, STB_S1); check_addr("i1_s1", 16'h0100, 16'h0000);

      // instruction 1: len 0, saturation, no new sample
      tick(); check_st("i1_s2", 4'd2, STB_S2);
      tick(); check_st("i1_s3", 4'd3, STB_S3); check_addr("i1_s3", 16'h3000, 16'h0040);
      tick(); check_st("i1_s5", 4'd5, STB_S5);
      tick(); check_st("i1_s6", 4'd6, STB_S6);
      tick(); check_st("i1_s8", 4'd8, STB_IDLE);
      tick(); check_st("i2_s1", 4'd1, STB_S1); check_addr("i2_s1", 16'h0200, 16'h0000);

      // remaining instructions, pc wraps back to 0
      for (int k = 3; k <= 16; k++) begin
         tick();
         wait_state($sformatf("pc%0d", k), 4'd1, 30);
         check($sformatf("pc%0d_addr", k), 32'(addr_bus_1.dram_addr), 32'(k % 16));
      end

      // en dropped during the MAC loop: finish instruction then park
      tick(); tick();
      check_st("en_off_s3", 4'd3, STB_S3);
      en = 1'b0;
      wait_state("en_off_s8", 4'd8, 20);
      tick(); check_st("en_off_idle", 4'd0, STB_IDLE);
      tick(); check_st("en_off_idle2", 4'd0, STB_IDLE);

      // resume at pc 1, then reset in the output state
      en = 1'b1;
      tick(); check_st("resume_s1", 4'd1, STB_S1); check_addr("resume_s1", 16'h0100, 16'h0000);
      wait_state("pre_rst_s6", 4'd6, 20);
      rst = 1'b1;
      tick(); check_st("rst_s6", 4'd0, STB_IDLE); check_addr("rst_s6", 16'h0000, 16'h0000);
      rst = 1'b0;
      tick(); check_st("post_rst_s1", 4'd1, STB_S1); check_addr("post_rst_s1", 16'h0000, 16'h0000);
      en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
